// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared states, fixed AR sideband values and master indices for axi_rd_arbiter.
package axi_rd_arb_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
    localparam logic [1:0] ARLOCK_DEF  = 2'b00;
    localparam logic [3:0] ARCACHE_DEF = 4'h0;
    localparam logic [2:0] ARPROT_DEF  = 3'h0;
    localparam int M_ICACHE   = 0;
    localparam int M_PREFETCH = 1;
    localparam int M_UNCACHED = 2;
    localparam int M_SPARE    = 3;
endpackage

// File: rtl/rd_arb_pick.sv
// rd_arb_pick: combinational winner select; AXI_RD_ARB_RR_EN selects round-robin, else fixed priority.
module rd_arb_pick
    import axi_rd_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_grant,
    output logic [1:0]      gnt_idx,
    output logic            gnt_any
);
    logic [1:0] start;
    logic [1:0] k;
`ifdef AXI_RD_ARB_RR_EN
    assign start = 2'((int'(last_grant) + 1) % NREQ);
`else
    // fixed priority always searches from master 0
    assign start = last_grant & 2'b00;
`endif
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        k       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = 2'((int'(start) + i) % NREQ);
            if (req[k]) begin
                gnt_idx = k;
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI3 read port among NREQ masters, one burst in flight; AXI_RD_ARB_RR_EN selects round-robin.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [NREQ*IDW-1:0] s_arid,
    input  logic [NREQ*32-1:0] s_araddr,
    input  logic [NREQ*4-1:0]  s_arlen,
    input  logic [NREQ*3-1:0]  s_arsize,
    input  logic [NREQ*2-1:0]  s_arburst,
    input  logic [NREQ-1:0]    s_arvalid,
    output logic [NREQ-1:0]    s_arready,
    output logic [IDW-1:0]     s_rid,
    output logic [31:0]        s_rdata,
    output logic [1:0]         s_rresp,
    output logic               s_rlast,
    output logic [NREQ-1:0]    s_rvalid,
    input  logic [NREQ-1:0]    s_rready,
    output logic [IDW-1:0]     arid,
    output logic [31:0]        araddr,
    output logic [3:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic [1:0]         arlock,
    output logic [3:0]         arcache,
    output logic [2:0]         arprot,
    output logic               arvalid,
    input  logic               arready,
    input  logic [IDW-1:0]     rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [1:0]         owner,
    output logic               busy,
    output logic               err
);
    arb_state_t     state_q, state_d;
    logic [1:0]     owner_q, owner_d;
    logic [IDW-1:0] id_q, id_d;
    logic [3:0]     len_q, len_d;
    logic [3:0]     beat_q, beat_d;
    logic           err_q, err_d;
    logic [1:0]     gnt_idx;
    logic           gnt_any;

    // owner already holds the most recent winner, so it doubles as last_grant
    rd_arb_pick #(.NREQ(NREQ)) u_pick (
        .req        (s_arvalid),
        .last_grant (owner_q),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign arid    = s_arid[owner_q*IDW +: IDW];
    assign araddr  = s_araddr[owner_q*32 +: 32];
    assign arlen   = s_arlen[owner_q*4 +: 4];
    assign arsize  = s_arsize[owner_q*3 +: 3];
    assign arburst = s_arburst[owner_q*2 +: 2];
    assign arlock  = ARLOCK_DEF;
    assign arcache = ARCACHE_DEF;
    assign arprot  = ARPROT_DEF;
    assign s_rid   = rid;
    assign s_rdata = rdata;
    assign s_rresp = rresp;
    assign s_rlast = rlast;
    assign owner   = owner_q;
    assign busy    = state_q != IDLE;
    assign err     = err_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        err_d     = err_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        s_arready = '0;
        s_rvalid  = '0;
        unique case (state_q)
            IDLE: if (gnt_any) begin
                owner_d = gnt_idx;
                id_d    = s_arid[gnt_idx*IDW +: IDW];
                len_d   = s_arlen[gnt_idx*4 +: 4];
                beat_d  = '0;
                state_d = ADDR;
            end
            ADDR: begin
                arvalid            = s_arvalid[owner_q];
                s_arready[owner_q] = arready;
                state_d            = (s_arvalid[owner_q] && arready) ? DATA : ADDR;
            end
            DATA: begin
                s_rvalid[owner_q] = rvalid;
                rready            = s_rready[owner_q];
                if (rvalid && s_rready[owner_q]) begin
                    beat_d  = beat_q + 4'd1;
                    // rlast must coincide exactly with the beat numbered arlen
                    err_d   = err_q | (rid != id_q) | (rlast != (beat_q == len_q));
                    state_d = rlast ? IDLE : DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            id_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            id_q    <= id_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: vector table, hand sequences and randomized bursts against a behavioural model.
module tb_axi_rd_arbiter;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] s_arid;
    logic [127:0] s_araddr;
    logic [15:0] s_arlen;
    logic [11:0] s_arsize;
    logic [7:0]  s_arburst;
    logic [3:0]  req;
    logic [3:0]  s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rvalid;
    logic [3:0]  s_rready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [1:0]  owner;
    logic        busy;
    logic        err;

    logic [31:0] m_addr [4];
    logic [3:0]  m_len [4];
    logic [3:0]  m_id [4];
    int n_pass = 0;
    int n_total = 0;
    int model_last;
    bit model_err;

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign s_arid[g*4 +: 4]     = m_id[g];
        assign s_araddr[g*32 +: 32] = m_addr[g];
        assign s_arlen[g*4 +: 4]    = m_len[g];
        assign s_arsize[g*3 +: 3]   = 3'(g);
        assign s_arburst[g*2 +: 2]  = 2'(g);
    end

    axi_rd_arbiter #(.NREQ(4), .IDW(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(req), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .owner(owner), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Winner chosen straight from the arbitration rule, not from any RTL structure
    function automatic int model_pick(input logic [3:0] r, input int last);
        int c;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_RD_ARB_RR_EN
            c = (last + 1 + k) % 4;
`else
            c = k;
`endif
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic do_reset();
        req = '0; arready = 0; rvalid = 0; rlast = 0; rid = '0; rdata = '0; rresp = '0; s_rready = '1;
        aresetn = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_s_arready", s_arready, 0);
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_owner", owner, 0);
        chk("rst_sideband", {arlock, arcache, arprot}, 0);
        @(posedge aclk); #1;
        aresetn = 1;
        model_last = 0;
        model_err = 0;
    endtask

    // Entered just after a clock edge in IDLE with req already driven
    task automatic serve(input int m, input int last_at, input logic [3:0] rr, input bit bp);
        @(posedge aclk); #1;
        chk("ar_owner", owner, m);
        chk("ar_busy", busy, 1);
        chk("ar_arvalid", arvalid, 1);
        chk("ar_araddr", araddr, m_addr[m]);
        chk("ar_arlen", arlen, m_len[m]);
        chk("ar_arid", arid, m_id[m]);
        chk("ar_arsize", arsize, m);
        arready = 1;
        #1 chk("ar_s_arready", s_arready, 4'b1 << m);
        @(posedge aclk); #1;
        arready = 0;
        req[m] = 0;
        chk("data_arvalid", arvalid, 0);
        for (int b = 0; b <= last_at; b++) begin
            rvalid = 1; rid = rr; rdata = $urandom; rresp = 2'(b); rlast = (b == last_at);
            if (bp && b == 2) begin
                for (int h = 0; h < 3; h++) begin
                    s_rready[m] = 0;
                    #1 chk("bp_rready", rready, 0);
                    chk("bp_s_rvalid", s_rvalid, 4'b1 << m);
                    @(posedge aclk); #1;
                end
                s_rready[m] = 1;
            end
            #1 chk("r_s_rvalid", s_rvalid, 4'b1 << m);
            chk("r_rready", rready, 1);
            chk("r_payload", {s_rdata, s_rid, s_rresp, s_rlast}, {rdata, rr, 2'(b), b == last_at});
            @(posedge aclk); #1;
        end
        rvalid = 0; rlast = 0;
        chk("end_busy", busy, 0);
        chk("end_arvalid", arvalid, 0);
    endtask

    typedef struct {
        int m; logic [31:0] addr; logic [3:0] len; logic [3:0] id;
        int last_at; logic [3:0] rr; bit bp; bit exp_err;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int exp_m;
        int last_at;
        logic [3:0] add;
        logic [3:0] rr;
        for (int g = 0; g < 4; g++) begin m_addr[g] = 32'h1000 * g; m_len[g] = '0; m_id[g] = 4'(g); end
        tbl[0] = '{1, 32'h1FC0_0040, 4'd7,  4'h1, 7,  4'h1, 1'b0, 1'b0};
        tbl[1] = '{0, 32'h0000_1000, 4'd3,  4'h0, 1,  4'h0, 1'b0, 1'b1};
        tbl[2] = '{2, 32'h8000_0000, 4'd2,  4'h2, 2,  4'h5, 1'b0, 1'b1};
        tbl[3] = '{3, 32'h0000_0ABC, 4'd5,  4'h7, 5,  4'h7, 1'b1, 1'b0};
        tbl[4] = '{0, 32'hFFFF_FFFC, 4'd0,  4'h3, 0,  4'h3, 1'b0, 1'b0};
        tbl[5] = '{1, 32'h2000_0010, 4'd2,  4'h9, 4,  4'h9, 1'b0, 1'b1};
        tbl[6] = '{3, 32'h3000_0000, 4'd15, 4'hF, 15, 4'hF, 1'b1, 1'b0};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            m_addr[tbl[i].m] = tbl[i].addr; m_len[tbl[i].m] = tbl[i].len; m_id[tbl[i].m] = tbl[i].id;
            req[tbl[i].m] = 1;
            serve(tbl[i].m, tbl[i].last_at, tbl[i].rr, tbl[i].bp);
            chk("vec_err", err, tbl[i].exp_err);
            m_len[tbl[i].m] = 0;
            req[tbl[i].m] = 1;
            serve(tbl[i].m, 0, tbl[i].id, 0);
            chk("vec_err_sticky", err, tbl[i].exp_err);
        end

        // Stray R beat while idle must be stalled, not routed
        do_reset();
        rvalid = 1; rlast = 1;
        #1 chk("stray_rready", rready, 0);
        chk("stray_s_rvalid", s_rvalid, 0);
        @(posedge aclk); #1;
        chk("stray_busy", busy, 0);
        rvalid = 0; rlast = 0;

        // Contention between masters 0 and 2 straight after reset
        do_reset();
        m_len[0] = 1; m_len[2] = 1;
        req = 4'b0101;
`ifdef AXI_RD_ARB_RR_EN
        exp_m = 2;
`else
        exp_m = 0;
`endif
        serve(exp_m, 1, m_id[exp_m], 0);
        chk("cont_loser_waiting", req[2 - exp_m], 1);
        serve(2 - exp_m, 1, m_id[2 - exp_m], 0);
        chk("cont_err", err, 0);

        // Reset on beat 3 of 8 aborts at once; arbitration restarts from reset state
        do_reset();
        m_len[2] = 7; req[2] = 1;
        @(posedge aclk); #1;
        arready = 1;
        @(posedge aclk); #1;
        arready = 0; req[2] = 0;
        for (int b = 0; b < 3; b++) begin
            rvalid = 1; rid = m_id[2]; rlast = 0;
            if (b < 2) begin @(posedge aclk); #1; end
        end
        aresetn = 0;
        #1 chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_s_rvalid", s_rvalid, 0);
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_owner", owner, 0);
        rvalid = 0;
        @(posedge aclk); #1;
        aresetn = 1;
        m_len[0] = 0; m_len[3] = 0;
        req = 4'b1001;
`ifdef AXI_RD_ARB_RR_EN
        exp_m = 3;
`else
        exp_m = 0;
`endif
        serve(exp_m, 0, m_id[exp_m], 0);
        serve(3 - exp_m, 0, m_id[3 - exp_m], 0);
        chk("post_rst_err", err, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            if (it % 10 == 0) do_reset();
            add = 4'($urandom_range(1, 15)) & ~req;
            for (int g = 0; g < 4; g++)
                if (add[g]) begin
                    m_addr[g] = $urandom; m_len[g] = 4'($urandom_range(0, 7)); m_id[g] = 4'($urandom);
                end
            req = req | add;
            exp_m = model_pick(req, model_last);
            model_last = exp_m;
            last_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : int'(m_len[exp_m]);
            rr = ($urandom_range(0, 11) == 0) ? 4'($urandom) : m_id[exp_m];
            model_err = model_err | (last_at != int'(m_len[exp_m])) | (rr != m_id[exp_m]);
            serve(exp_m, last_at, rr, $urandom_range(0, 3) == 0);
            chk("rnd_err", err, model_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares one AXI3 read port (AR/R channels) between NREQ instruction-side read masters: icache line refill, pre_fetch buffer fill, uncached instruction fetch and one spare. Sits between the IF-stage cache/prefetch/uncached engines and the core's external read interface. It carries one outstanding burst at a time, routes R beats back to the owning master, and checks burst length against `rlast`.

## Interface
Parameters:
- `NREQ`, 4: number of requesting masters; index 0 is the icache refill.
- `IDW`, 4: AXI ID width.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_arid` in NREQ*IDW: per-master ARID, packed with master i at `[i*IDW +: IDW]`.
- `s_araddr` in NREQ*32: per-master ARADDR.
- `s_arlen` in NREQ*4: per-master ARLEN.
- `s_arsize` in NREQ*3: per-master ARSIZE.
- `s_arburst` in NREQ*2: per-master ARBURST.
- `s_arvalid` in NREQ: per-master ARVALID.
- `s_arready` out NREQ: per-master ARREADY.
- `s_rid` out IDW: RID, broadcast to all masters.
- `s_rdata` out 32: RDATA, broadcast to all masters.
- `s_rresp` out 2: RRESP, broadcast to all masters.
- `s_rlast` out 1: RLAST, broadcast to all masters.
- `s_rvalid` out NREQ: per-master RVALID, asserted only for the owner.
- `s_rready` in NREQ: per-master RREADY.
- `arid` out IDW: downstream ARID.
- `araddr` out 32: downstream ARADDR.
- `arlen` out 4: downstream ARLEN.
- `arsize` out 3: downstream ARSIZE.
- `arburst` out 2: downstream ARBURST.
- `arlock` out 2: downstream ARLOCK, constant 0.
- `arcache` out 4: downstream ARCACHE, constant 0.
- `arprot` out 3: downstream ARPROT, constant 0.
- `arvalid` out 1: downstream ARVALID.
- `arready` in 1: downstream ARREADY.
- `rid` in IDW: downstream RID.
- `rdata` in 32: downstream RDATA.
- `rresp` in 2: downstream RRESP.
- `rlast` in 1: downstream RLAST.
- `rvalid` in 1: downstream RVALID.
- `rready` out 1: downstream RREADY.
- `owner` out 2: index of the current grant; debug.
- `busy` out 1: high when the state is not IDLE.
- `err` out 1: sticky burst-length or RID error; cleared only by reset.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any `s_arvalid` is high, pick a winner, latch it in `owner`, latch its ARID and ARLEN, clear `beat_cnt`, then go to ADDR.
  - `s_arready` is all zero in IDLE.
- ADDR:
  - Downstream AR fields are muxed combinationally from master `owner`.
  - `arvalid` = `s_arvalid[owner]`.
  - `s_arready[owner]` = `arready`; all other `s_arready` bits are 0.
  - On `arvalid && arready`, go to DATA.
- DATA:
  - `s_rvalid[owner]` = `rvalid`; `rready` = `s_rready[owner]`. R payload is broadcast.
  - Each beat (`rvalid && rready`) increments `beat_cnt` (4-bit, wraps at 16).
  - Final beat (`rvalid && rready && rlast`): go to IDLE.
  - `err` is set if, on the final beat, `beat_cnt != latched arlen`.
  - `err` is set if `beat_cnt == arlen` on a beat that does not carry `rlast`.
  - `err` is set if any beat has `rid != latched arid`.
  - Beats are forwarded unchanged even when an error is flagged.
- Outside DATA: `rready` = 0 and `s_rvalid` = 0. Stray R beats are back-pressured, never dropped.
- A master that drops `s_arvalid` while in ADDR is not AXI-compliant. The FSM holds ADDR with `arvalid` low until it reasserts; no timeout.

## Timing
- Reset (`aresetn` = 0, asynchronous): state = IDLE, `owner` = 0, `beat_cnt` = 0, `err` = 0, `busy` = 0, `arvalid` = 0, `rready` = 0, `s_arready` = 0, `s_rvalid` = 0.
- Reset asserted mid-burst aborts the burst immediately. Downstream must be reset together with this block.
- Arbitration latency: a request sampled in IDLE at cycle N drives `arvalid` at cycle N+1. Minimum 1 bubble per transaction.
- The final beat of a burst and the next grant cannot share a cycle. The next AR is issued at least 2 cycles after the final beat.
- AR and R paths are combinational passthroughs, except `owner`, the latched ID/len and the FSM.
- Simultaneous requests in IDLE resolve per the Configuration rule. Losers keep `s_arvalid` high and are granted in later IDLE cycles.

## Configuration
- `AXI_RD_ARB_RR_EN` defined: round-robin.
  - A 2-bit `last_grant` register (reset 0) tracks the last winner.
  - Search starts at `last_grant + 1` mod NREQ.
  - `last_grant` updates when IDLE goes to ADDR.
- Not defined: fixed priority; the lowest index wins and `last_grant` is not instantiated.

## Structure
- Package `axi_rd_arb_pkg`:
  - State enum `arb_state_t` {IDLE, ADDR, DATA}.
  - Constants `ARLOCK_DEF`, `ARCACHE_DEF`, `ARPROT_DEF`.
  - Master index localparams `M_ICACHE`=0, `M_PREFETCH`=1, `M_UNCACHED`=2, `M_SPARE`=3.
- One sub-module, `rd_arb_pick`.
  - Combinational winner select with inputs `req[NREQ]` and `last_grant`, and outputs `gnt_idx` and `gnt_any`.
  - The RR/fixed-priority macro lives only inside `rd_arb_pick`.

## Test plan
- Single request: `s_arvalid[1]` with `araddr` 0x1FC0_0040, `arlen` 7 → `arvalid` one cycle later with the same address. 8 beats reach `s_rvalid[1]` only; `busy` drops after the beat with `rlast`; `err` = 0.
- Contention: masters 0 and 2 both request in IDLE with RR enabled and `last_grant` = 0 → master 2 is served first, then master 0.
  - Same stimulus with the macro undefined → master 0 first.
- Back-pressure: `s_rready[owner]` = 0 for 3 cycles mid-burst → `rready` = 0 for those cycles; `beat_cnt` holds; no data lost.
- Length error: `arlen` 3, downstream asserts `rlast` on beat 2 → `err` = 1 and stays 1. FSM returns to IDLE; the next transaction is served normally.
- RID mismatch: ARID 4'h2, downstream returns RID 4'h5 → `err` = 1 and the data is still forwarded.
- Reset in DATA: `aresetn` low on beat 3 of 8 → `arvalid`, `rready`, `s_rvalid` and `busy` go to 0 immediately; after release the first request is granted per the Configuration rule.
